// File: rtl/sigma_delta_pkg.sv
// Shared types and the round-robin helper for the sigma-delta ADC arbiter.
package sigma_delta_pkg;

   typedef enum logic [1:0] {
      CH_OFF,
      CH_SETTLE,
      CH_RUN
   } ch_state_t;

   localparam int MAX_CHANNELS = 16;

   // First set bit of mask strictly after ptr, wrapping modulo n; returns ptr when mask is empty.
   function automatic logic [3:0] rr_next(input logic [MAX_CHANNELS-1:0] mask,
                                          input logic [3:0]              ptr,
                                          input int                      n);
      int idx;
      rr_next = ptr;
      for (int k = MAX_CHANNELS; k >= 1; k--) begin
         idx = (int'(ptr) + k) % n;
         if (k <= n && mask[idx[3:0]]) rr_next = idx[3:0];
      end
   endfunction

endpackage

// File: rtl/sigma_delta_adc_channel_slot.sv
// One ADC channel: enable/settle FSM, single-sample holding register and sticky overrun flag.
module sigma_delta_adc_channel_slot
   import sigma_delta_pkg::*;
#(
   parameter int ADC_BITLEN     = 24,
   parameter int SETTLE_SAMPLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_enable,
   input  logic [ADC_BITLEN-1:0] i_adc_data,
   input  logic                  i_adc_valid,
   input  logic                  i_drain,
   input  logic                  i_overrun_clear,
   output logic                  o_adc_rst,
   output logic [ADC_BITLEN-1:0] o_data,
   output logic                  o_full,
   output logic                  o_overrun
);

   localparam int CNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

   ch_state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [ADC_BITLEN-1:0] r_data;
   logic                  r_full;
   logic                  r_overrun;
   logic                  w_capture;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CH_OFF;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // NOTE: defaults first, so every path assigns every output and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!i_enable) begin
         w_state_nxt = CH_OFF;
      end else begin
         case (r_state)
            CH_OFF: begin
               w_cnt_nxt   = CNT_W'(SETTLE_SAMPLES);
               w_state_nxt = (SETTLE_SAMPLES == 0) ? CH_RUN : CH_SETTLE;
            end
            CH_SETTLE: begin
               if (i_adc_valid) begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) w_state_nxt = CH_RUN;
               end
            end
            CH_RUN:  w_state_nxt = CH_RUN;
            default: w_state_nxt = CH_OFF;
         endcase
      end
   end

   assign w_capture = i_enable && (r_state == CH_RUN) && i_adc_valid;

   // A new sample wins over a drain in the same cycle; overrun only when nothing left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (!i_enable)      r_full <= 1'b0;
         else if (w_capture) r_full <= 1'b1;
         else if (i_drain)   r_full <= 1'b0;

         if (w_capture && r_full && !i_drain) r_overrun <= 1'b1;
         else if (i_overrun_clear)            r_overrun <= 1'b0;
      end
   end

   // NOTE: sample storage needs no reset; r_full qualifies it.
   always_ff @(posedge clk) begin
      if (w_capture) r_data <= i_adc_data;
   end

   assign o_adc_rst = (r_state == CH_OFF);
   assign o_data    = r_data;
   assign o_full    = r_full && i_enable;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/sigma_delta_adc_arbiter.sv
// Sequences a bank of sigma-delta ADCs and serializes their samples round-robin onto one stream.
module sigma_delta_adc_arbiter
   import sigma_delta_pkg::*;
#(
   parameter  int NUM_CHANNELS   = 4,
   parameter  int ADC_BITLEN     = 24,
   parameter  int SETTLE_SAMPLES = 2,
   localparam int CH_W           = $clog2(NUM_CHANNELS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_CHANNELS-1:0]          ch_enable,
   output logic [NUM_CHANNELS-1:0]          adc_rst,
   input  logic [NUM_CHANNELS*ADC_BITLEN-1:0] adc_output,
   input  logic [NUM_CHANNELS-1:0]          adc_valid,
   output logic [ADC_BITLEN-1:0]            out_data,
   output logic [CH_W-1:0]                  out_channel,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [NUM_CHANNELS-1:0]          overrun,
   input  logic                             overrun_clear
);

   logic [NUM_CHANNELS-1:0] w_full;
   logic [NUM_CHANNELS-1:0] w_drain;
   logic [ADC_BITLEN-1:0]   w_slot_data [NUM_CHANNELS];
   logic [CH_W-1:0]         w_grant_idx;
   logic                    w_load;
   logic                    w_any;

   logic [CH_W-1:0]         r_ptr;
   logic                    r_out_valid;
   logic [ADC_BITLEN-1:0]   r_out_data;
   logic [CH_W-1:0]         r_out_channel;

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_slot
      sigma_delta_adc_channel_slot #(
         .ADC_BITLEN     (ADC_BITLEN),
         .SETTLE_SAMPLES (SETTLE_SAMPLES)
      ) u_slot (
         .clk             (clk),
         .rst_n           (rst_n),
         .i_enable        (ch_enable[g]),
         .i_adc_data      (adc_output[g*ADC_BITLEN +: ADC_BITLEN]),
         .i_adc_valid     (adc_valid[g]),
         .i_drain         (w_drain[g]),
         .i_overrun_clear (overrun_clear),
         .o_adc_rst       (adc_rst[g]),
         .o_data          (w_slot_data[g]),
         .o_full          (w_full[g]),
         .o_overrun       (overrun[g])
      );
   end

   // The output register refills whenever it is empty or being consumed this cycle.
   assign w_load      = !r_out_valid || out_ready;
   assign w_any       = |w_full;
   assign w_grant_idx = CH_W'(rr_next(MAX_CHANNELS'(w_full), 4'(r_ptr), NUM_CHANNELS));

   always_comb begin
      w_drain = '0;
      if (w_load && w_any) w_drain[w_grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_channel <= '0;
         r_ptr         <= CH_W'(NUM_CHANNELS - 1);
      end else if (w_load) begin
         r_out_valid <= w_any;
         if (w_any) begin
            r_out_data    <= w_slot_data[w_grant_idx];
            r_out_channel <= w_grant_idx;
            r_ptr         <= w_grant_idx;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_channel = r_out_channel;

endmodule
